fetch_sequencer: RTL and testbench

- Control-side partner of the program counter: consumes the fetched instruction word and current PC, and drives the PC's Start, BranchAbsEn, BranchRelEn, RelTarget and AbsTarget inputs.
- Runs one program per request through a small FSM and decodes branch instructions into PC controls.
- Holds a writable 32-entry absolute-jump lookup table.
- Stops on a halt instruction, or optionally on a cycle-budget timeout.

---
 rtl/fetch_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Control-side partner of the program counter. On a request it pulses Start
// to the PC, then watches each fetched instruction word and turns branch
// opcodes into PC controls until a halt (or a PC run-off) ends the program.
// A writable 32-entry table supplies absolute jump targets.
//
// Optional build macro:
//   FETCH_TIMEOUT_EN  - when defined, a program that runs for MAX_CYCLES
//                       RUN cycles without halting is ended with Timeout=1.
//                       When undefined, Timeout is tied to 0.
//
// Ports:
//   Clk          in   system clock, all state on the rising edge
//   Reset        in   synchronous active-high reset
//   Req          in   run request (level, held until Done is seen)
//   InstIn       in   instruction word at the current PC
//   ProgCtr      in   current PC (only used for run-off detection)
//   LutWe        in   jump-table write enable
//   LutAddr      in   jump-table write index
//   LutData      in   jump-table write data
//   Start        out  one-cycle start pulse to the PC
//   BranchAbsEn  out  unconditional absolute jump
//   BranchRelEn  out  conditional relative jump
//   RelTarget    out  sign-extended relative offset
//   AbsTarget    out  absolute target read from the jump table
//   Done         out  program finished (registered)
//   Timeout      out  program ended by budget expiry
//   CycleCount   out  RUN cycles used by the last or current program
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned REL_W      = 8,
   parameter int unsigned INST_W     = 9,
   parameter int unsigned LUT_DEPTH  = 32,
   parameter int unsigned MAX_CYCLES = 4095
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic [INST_W-1:0] InstIn,
   input  logic [PC_W-1:0]   ProgCtr,
   input  logic              LutWe,
   input  logic [4:0]        LutAddr,
   input  logic [PC_W-1:0]   LutData,
   output logic              Start,
   output logic              BranchAbsEn,
   output logic              BranchRelEn,
   output logic [REL_W-1:0]  RelTarget,
   output logic [PC_W-1:0]   AbsTarget,
   output logic              Done,
   output logic              Timeout,
   output logic [11:0]       CycleCount
);

   localparam int unsigned       CNT_W   = 12;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [INST_W-1:0] OP_HALT = '1;
   localparam logic [PC_W-1:0]   PC_LAST = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [PC_W-1:0]    lut_q [LUT_DEPTH];

   logic               is_family;
   logic               is_halt_op;
   logic               is_abs;
   logic               is_rel;
   logic               halt;
   logic               expire;
   logic               start_c;
   logic               abs_en_c;
   logic               rel_en_c;
   logic signed [REL_W-1:0] rel_off;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // 5-bit two's-complement branch offset widened to the PC offset width.
   function automatic logic signed [REL_W-1:0] sext_off(input logic [4:0] off);
      return REL_W'($signed(off));
   endfunction

   // ------------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------------
   // HALT (all ones) sits inside the branch family with bit 5 set, so it must
   // be carved out before the absolute-jump decode.
   assign is_family  = (InstIn[8:6] == 3'b111);
   assign is_halt_op = (InstIn == OP_HALT);
   assign is_abs     = is_family && InstIn[5] && !is_halt_op;
   assign is_rel     = is_family && !InstIn[5];
   // Falling off the last PC address with no branch pending ends the program.
   assign halt       = is_halt_op || ((ProgCtr == PC_LAST) && !is_abs && !is_rel);
   assign rel_off    = sext_off(InstIn[4:0]);

`ifdef FETCH_TIMEOUT_EN
   // Expiry fires in the RUN cycle whose increment brings the count to the
   // budget, so CycleCount reads exactly MAX_CYCLES afterwards.
   assign expire = ({20'd0, cnt_q} + 32'd1) >= MAX_CYCLES;
`else
   localparam int unsigned unused_max_cycles = MAX_CYCLES;
   assign expire = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and branch controls
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      start_c  = 1'b0;
      abs_en_c = 1'b0;
      rel_en_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (Req) begin
               state_d = LAUNCH;
            end
         end

         LAUNCH: begin
            start_c = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
         end

         RUN: begin
            cnt_d = sat_inc(cnt_q);
            if (halt) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (expire) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               abs_en_c = is_abs;
               rel_en_c = is_rel;
            end
         end

         DONE: begin
            // Req is a level: wait for the requester to drop it before
            // re-arming, otherwise the same request would launch twice.
            if (!Req) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Timeout flag
   // ------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
   logic to_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         to_q <= 1'b0;
      end else if ((state_q == RUN) && !halt && expire) begin
         to_q <= 1'b1;
      end else if ((state_q == DONE) && !Req) begin
         to_q <= 1'b0;
      end
   end

   assign Timeout = to_q;
`else
   assign Timeout = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Jump table
   // ------------------------------------------------------------------------
   // Reads are combinational from the stored array, so a write and a read of
   // the same index in one cycle returns the old entry.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < int'(LUT_DEPTH); i++) begin
            lut_q[i] <= '0;
         end
      end else if (LutWe) begin
         lut_q[LutAddr] <= LutData;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign Start       = start_c;
   assign BranchAbsEn = abs_en_c;
   assign BranchRelEn = rel_en_c;
   assign AbsTarget   = abs_en_c ? lut_q[InstIn[4:0]] : '0;
   assign RelTarget   = rel_en_c ? rel_off : '0;
   assign Done        = done_q;
   assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for fetch_sequencer: directed programs with a behavioural model
// compared on every falling edge, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int MAXC = 20;

   localparam int PH_IDLE   = 0;
   localparam int PH_LAUNCH = 1;
   localparam int PH_RUN    = 2;
   localparam int PH_DONE   = 3;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Req;
   logic [8:0]  InstIn;
   logic [9:0]  ProgCtr;
   logic        LutWe;
   logic [4:0]  LutAddr;
   logic [9:0]  LutData;
   logic        Start;
   logic        BranchAbsEn;
   logic        BranchRelEn;
   logic [7:0]  RelTarget;
   logic [9:0]  AbsTarget;
   logic        Done;
   logic        Timeout;
   logic [11:0] CycleCount;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 Clk = ~Clk;

   fetch_sequencer #(
      .PC_W(10), .REL_W(8), .INST_W(9), .LUT_DEPTH(32), .MAX_CYCLES(MAXC)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .InstIn(InstIn), .ProgCtr(ProgCtr),
      .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
      .Start(Start), .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn),
      .RelTarget(RelTarget), .AbsTarget(AbsTarget), .Done(Done),
      .Timeout(Timeout), .CycleCount(CycleCount)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------- behavioural model ---------------------------
   int         m_ph  = PH_IDLE;
   int         m_cnt = 0;
   bit         m_to  = 1'b0;
   logic [9:0] m_lut [32];

   function bit m_is_branch();
      return (InstIn[8:6] == 3'b111) && (InstIn != 9'h1FF);
   endfunction

   function bit m_halt();
      return (m_ph == PH_RUN) &&
             ((InstIn == 9'h1FF) || ((ProgCtr == 10'h3FF) && !m_is_branch()));
   endfunction

   function bit m_expire();
`ifdef FETCH_TIMEOUT_EN
      return (m_ph == PH_RUN) && !m_halt() && (m_cnt + 1 >= MAXC);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         m_ph  <= PH_IDLE;
         m_cnt <= 0;
         m_to  <= 1'b0;
         for (int i = 0; i < 32; i++) m_lut[i] <= '0;
      end else begin
         if (LutWe) m_lut[LutAddr] <= LutData;
         if (m_ph == PH_IDLE && Req) m_ph <= PH_LAUNCH;
         if (m_ph == PH_LAUNCH) begin
            m_cnt <= 0;
            m_ph  <= PH_RUN;
         end
         if (m_ph == PH_RUN) begin
            m_cnt <= (m_cnt < 4095) ? m_cnt + 1 : 4095;
            if (m_halt()) m_ph <= PH_DONE;
            else if (m_expire()) begin
               m_ph <= PH_DONE;
               m_to <= 1'b1;
            end
         end
         if (m_ph == PH_DONE && !Req) begin
            m_ph <= PH_IDLE;
            m_to <= 1'b0;
         end
      end
   end

   // ------------------------- per-cycle compare ---------------------------
   always @(negedge Clk) begin
      if (chk_en) begin
         bit         live;
         bit         e_abs;
         bit         e_rel;
         int         off;
         logic [7:0] e_rt;
         logic [9:0] e_at;
         live  = (m_ph == PH_RUN) && !m_halt() && !m_expire() && m_is_branch();
         e_abs = live && InstIn[5];
         e_rel = live && !InstIn[5];
         off   = int'(InstIn[4:0]);
         if (off > 15) off = off - 32;
         e_rt  = e_rel ? off[7:0] : 8'h00;
         e_at  = e_abs ? m_lut[InstIn[4:0]] : 10'h000;
         chk("m_start", Start, (m_ph == PH_LAUNCH));
         chk("m_abs_en", BranchAbsEn, e_abs);
         chk("m_rel_en", BranchRelEn, e_rel);
         chk("m_rel_tgt", RelTarget, e_rt);
         chk("m_abs_tgt", AbsTarget, e_at);
         chk("m_done", Done, (m_ph == PH_DONE));
         chk("m_timeout", Timeout, m_to);
         chk("m_count", CycleCount, m_cnt);
      end
   end

   // ------------------------- directed stimulus ---------------------------
   task automatic step(input logic rst, input logic rq, input logic [8:0] inst,
                       input logic [9:0] pc);
      @(posedge Clk);
      #1;
      Reset   = rst;
      Req     = rq;
      InstIn  = inst;
      ProgCtr = pc;
      LutWe   = 1'b0;
   endtask

   logic [8:0] nb [7] = '{9'h000, 9'h0AA, 9'h1BF, 9'h155, 9'h0DF, 9'h180, 9'h03F};

   initial begin
      Reset = 1'b1; Req = 1'b0; InstIn = '0; ProgCtr = '0;
      LutWe = 1'b0; LutAddr = '0; LutData = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk_en = 1'b1;
      #2;
      chk("rst_start", Start, 0);
      chk("rst_done", Done, 0);
      chk("rst_count", CycleCount, 0);

      // Program 1: table writes, branch decode, same-cycle write, run-off
      step(0, 0, 9'h000, 0); LutWe = 1; LutAddr = 3; LutData = 10'd10;
      step(0, 0, 9'h000, 0); LutWe = 1; LutAddr = 7; LutData = 10'h155;
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'h000, 0); #2;
      chk("start_pulse", Start, 1);
      step(0, 1, 9'b111_1_00011, 0); #2;
      chk("start_gone", Start, 0);
      chk("run_entry_cnt", CycleCount, 0);
      chk("abs_en", BranchAbsEn, 1);
      chk("abs_tgt", AbsTarget, 10);
      chk("abs_no_rel", BranchRelEn, 0);
      step(0, 0, 9'b111_0_11011, 5); #2;
      chk("rel_en", BranchRelEn, 1);
      chk("rel_neg5", RelTarget, 8'hFB);
      step(0, 0, 9'b111_0_00101, 6); #2;
      chk("rel_pos5", RelTarget, 8'h05);
      step(0, 0, 9'b111_1_00111, 7); LutWe = 1; LutAddr = 7; LutData = 10'h2AA; #2;
      chk("lut_old_val", AbsTarget, 10'h155);
      step(0, 0, 9'b111_1_00111, 8); #2;
      chk("lut_new_val", AbsTarget, 10'h2AA);
      step(0, 0, 9'b111_0_11111, 10'h3FF); #2;
      chk("branch_at_last_pc", BranchRelEn, 1);
      chk("rel_neg1", RelTarget, 8'hFF);
      step(0, 0, 9'h0AA, 10'h3FF); #2;
      chk("runoff_no_rel", BranchRelEn, 0);
      step(0, 0, 9'h000, 0); #2;
      chk("runoff_done", Done, 1);
      chk("runoff_count", CycleCount, 7);
      step(0, 0, 9'h000, 0); #2;
      chk("runoff_idle", Done, 0);

      // Program 2: seven plain instructions then HALT
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'h000, 0);
      for (int i = 0; i < 7; i++) step(0, 1, nb[i], 10'(i));
      step(0, 1, 9'h1FF, 7); #2;
      chk("halt_no_abs", BranchAbsEn, 0);
      step(0, 1, 9'h000, 8); #2;
      chk("halt_done", Done, 1);
      chk("halt_count", CycleCount, 8);
      step(0, 1, 9'b111_1_00011, 9); #2;
      chk("done_no_branch", BranchAbsEn, 0);
      chk("done_count_frozen", CycleCount, 8);
      step(0, 0, 9'h000, 0);
      step(0, 0, 9'h000, 0); #2;
      chk("idle_done_clear", Done, 0);

      // Program 3: reset while an absolute jump is being driven
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'b111_1_00011, 0); #2;
      chk("pre_rst_abs", BranchAbsEn, 1);
      step(1, 1, 9'b111_1_00011, 1); #2;
      chk("rst_pending_abs", BranchAbsEn, 1);
      step(0, 0, 9'b111_1_00011, 2); #2;
      chk("post_rst_abs", BranchAbsEn, 0);
      chk("post_rst_tgt", AbsTarget, 0);
      chk("post_rst_count", CycleCount, 0);

      // Program 4: table cleared by reset, then budget behaviour
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'h000, 0);
      step(0, 1, 9'b111_1_00011, 0); #2;
      chk("lut3_cleared", AbsTarget, 0);
      step(0, 1, 9'b111_1_00111, 1); #2;
      chk("lut7_cleared", AbsTarget, 0);
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 40 && !Done; i++) step(0, 1, 9'h0AA, 10'(i + 2));
      #2;
      chk("to_done", Done, 1);
      chk("to_flag", Timeout, 1);
      chk("to_count", CycleCount, MAXC);
`else
      for (int i = 0; i < 4100; i++) step(0, 1, 9'h0AA, 10'(i % 512));
      #2;
      chk("sat_count", CycleCount, 4095);
      chk("no_timeout_done", Done, 0);
      chk("no_timeout_flag", Timeout, 0);
      step(0, 1, 9'h1FF, 0);
      step(0, 1, 9'h000, 0); #2;
      chk("sat_halt_done", Done, 1);
      chk("sat_halt_to", Timeout, 0);
`endif
      step(0, 0, 9'h000, 0);
      step(0, 0, 9'h000, 0); #2;
      chk("final_idle", Done, 0);
      chk("final_to", Timeout, 0);

      step(0, 0, 9'h000, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
